// File: rtl/picorv32_seq_shifter.sv
`default_nettype none
// ============================================================================
// Module      : picorv32_seq_shifter
// Description : Multi-cycle SLL/SRL/SRA unit with valid/ready request and
//               response handshakes, stepping by 4 or 1 bit per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module picorv32_seq_shifter #(
    parameter int TWO_STAGE_SHIFT = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_op1,
    input  logic [4:0]  req_shamt,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] data_q, data_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        right_q, right_d;
    logic        fill_q, fill_d;
    logic [31:0] rsp_data_q, rsp_data_d;

    logic        w_step4;
    logic [4:0]  w_step;
    logic [4:0]  w_cnt_next;
    logic [31:0] w_shl;
    logic [31:0] w_shr;
    logic [31:0] w_shifted;

    assign w_step4    = (TWO_STAGE_SHIFT != 0) && (cnt_q >= 5'd4);
    assign w_step     = w_step4 ? 5'd4 : 5'd1;
    assign w_cnt_next = cnt_q - w_step;
    assign w_shl      = w_step4 ? {data_q[27:0], 4'b0000} : {data_q[30:0], 1'b0};
    assign w_shr      = w_step4 ? {{4{fill_q}}, data_q[31:4]} : {fill_q, data_q[31:1]};
    assign w_shifted  = right_q ? w_shr : w_shl;

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        cnt_d      = cnt_q;
        right_d    = right_q;
        fill_d     = fill_q;
        rsp_data_d = rsp_data_q;
        // Flush wins over any handshake, including an accept in IDLE.
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        data_d  = req_op1;
                        cnt_d   = req_shamt;
                        right_d = req_op[0];
                        fill_d  = (req_op == 2'b11) && req_op1[31];
                        if (req_shamt == 5'd0) begin
                            state_d    = S_DONE;
                            rsp_data_d = req_op1;
                        end else begin
                            state_d = S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    data_d = w_shifted;
                    cnt_d  = w_cnt_next;
                    if (w_cnt_next == 5'd0) begin
                        state_d    = S_DONE;
                        rsp_data_d = w_shifted;
                    end
                end
                S_DONE: begin
                    if (rsp_ready) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            data_q     <= 32'd0;
            cnt_q      <= 5'd0;
            right_q    <= 1'b0;
            fill_q     <= 1'b0;
            rsp_data_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            cnt_q      <= cnt_d;
            right_q    <= right_d;
            fill_q     <= fill_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign rsp_data  = rsp_data_q;

endmodule
`default_nettype wire

// File: tb/tb_picorv32_seq_shifter.sv
`default_nettype none
// ============================================================================
// Module      : tb_picorv32_seq_shifter
// Description : Scoreboard bench: stimulus pushes expected result and arrival
//               cycle, a monitor pops and compares when rsp_valid rises.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_picorv32_seq_shifter;

    localparam int TS = 1;

    logic        clk = 1'b0;
    logic        resetn;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_op1;
    logic [4:0]  req_shamt;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        busy;

    typedef struct {
        logic [31:0] d;
        int          c;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    bit   seen  = 1'b0;

    picorv32_seq_shifter #(.TWO_STAGE_SHIFT(TS)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (flush),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_op1   (req_op1),
        .req_shamt (req_shamt),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int lat(input logic [4:0] sh);
        return 1 + ((TS != 0) ? (int'(sh) / 4 + int'(sh) % 4) : int'(sh));
    endfunction

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [4:0] sh);
        case (op)
            2'b01:   return a >> sh;
            2'b11:   return $unsigned($signed(a) >>> sh);
            default: return a << sh;
        endcase
    endfunction

    // Monitor: compare data and arrival cycle on each rising rsp_valid.
    always @(negedge clk) begin
        if (rsp_valid && !seen) begin
            seen = 1'b1;
            if (q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_rsp: got %h expected no response", rsp_data);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("rsp_data", rsp_data, e.d);
                chk("rsp_cycle", 32'(cyc), 32'(e.c));
            end
        end
        if (!rsp_valid) seen = 1'b0;
    end

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [4:0] sh,
                         input logic [31:0] exp);
        int t;
        t = 0;
        req_op    = op;
        req_op1   = a;
        req_shamt = sh;
        req_valid = 1'b1;
        while (!req_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            chk("accept_timeout", 32'(t), 32'd0);
            req_valid = 1'b0;
            return;
        end
        q.push_back('{exp, cyc + lat(sh)});
        @(negedge clk);
        req_valid = 1'b0;
        req_op1   = 32'hA5A5_5A5A;
        req_shamt = 5'd17;
    endtask

    task automatic wait_empty();
        int t;
        t = 0;
        while (q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            chk("rsp_timeout", 32'(q.size()), 32'd0);
            q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; flush = 1'b0; req_valid = 1'b0; req_op = 2'b00;
        req_op1 = 32'd0; req_shamt = 5'd0; rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("reset_req_ready", 32'(req_ready), 32'd1);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_rsp_data", rsp_data, 32'd0);

        issue(2'b11, 32'h8000_00F0, 5'd4,  32'hF800_000F); wait_empty();
        issue(2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000); wait_empty();
        issue(2'b01, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF); wait_empty();
        issue(2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001); wait_empty();
        issue(2'b11, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF); wait_empty();
        issue(2'b10, 32'h0000_FFFF, 5'd8,  32'h00FF_FF00); wait_empty();
        issue(2'b11, 32'h7FFF_FFFF, 5'd5,  32'h03FF_FFFF); wait_empty();
        issue(2'b01, 32'hF000_0000, 5'd3,  32'h1E00_0000); wait_empty();
        issue(2'b00, 32'h1234_5678, 5'd7,  32'h1A2B_3C00); wait_empty();

        // Response back-pressure: result must hold and no new request may enter.
        rsp_ready = 1'b0;
        issue(2'b00, 32'h0000_00FF, 5'd4, 32'h0000_0FF0);
        for (int i = 0; i < 20 && !rsp_valid; i++) @(negedge clk);
        req_valid = 1'b1; req_op = 2'b01; req_op1 = 32'h1111_1111; req_shamt = 5'd0;
        for (int i = 0; i < 5; i++) begin
            chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("hold_rsp_data", rsp_data, 32'h0000_0FF0);
            chk("hold_req_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("release_busy", 32'(busy), 32'd0);
        chk("release_q_empty", 32'(q.size()), 32'd0);

        // Flush mid-shift: the in-flight result must never appear.
        issue(2'b01, 32'hFFFF_0000, 5'd20, 32'h0000_0FFF);
        repeat (2) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("flush_rsp_data_kept", rsp_data, 32'h0000_0FF0);
        flush = 1'b0;
        q.delete();
        repeat (30) @(negedge clk);
        flush = 1'b1; req_valid = 1'b1; req_op = 2'b00; req_op1 = 32'h1; req_shamt = 5'd1;
        @(negedge clk);
        chk("flush_blocks_accept", 32'(busy), 32'd0);
        flush = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        issue(2'b01, 32'hF0F0_F0F0, 5'd20, 32'h0000_0F0F); wait_empty();

        // Asynchronous reset in the middle of a shift.
        issue(2'b00, 32'h0000_00AB, 5'd31, 32'h8000_0000);
        @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("areset_busy", 32'(busy), 32'd0);
        chk("areset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("areset_rsp_data", rsp_data, 32'd0);
        q.delete();
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("post_reset_req_ready", 32'(req_ready), 32'd1);

        for (int i = 0; i < 8; i++) begin
            logic [1:0]  op;
            logic [31:0] a;
            logic [4:0]  sh;
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            sh = 5'($urandom_range(0, 31));
            issue(op, a, sh, model(op, a, sh));
            wait_empty();
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
